// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 64-bit ALU between two requesters with registered responses
module alu_arbiter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp_rd,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, owner_q, owner_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic gnt1, acc, rsp_hs, illegal, alu_c, alu_v;
  logic [XLEN:0] sum, diff;
  logic [XLEN-1:0] alu_y;
  logic [5:0] shamt;
  // SUB carry is the borrow out, i.e. rs1 < rs2 unsigned
  always_comb begin
    sum = {1'b0, rs1_q} + {1'b0, rs2_q};
    diff = {1'b0, rs1_q} - {1'b0, rs2_q};
    shamt = rs2_q[5:0];
    illegal = ctrl_q > 4'd9;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (ctrl_q)
      4'd0: alu_y = rs1_q & rs2_q;
      4'd1: alu_y = rs1_q | rs2_q;
      4'd2: begin
        alu_y = sum[XLEN-1:0];
        alu_c = sum[XLEN];
        alu_v = (rs1_q[XLEN-1] == rs2_q[XLEN-1]) && (sum[XLEN-1] != rs1_q[XLEN-1]);
      end
      4'd3: alu_y = rs1_q ^ rs2_q;
      4'd4: alu_y = rs1_q << shamt;
      4'd5: alu_y = rs1_q >> shamt;
      4'd6: begin
        alu_y = diff[XLEN-1:0];
        alu_c = diff[XLEN];
        alu_v = (rs1_q[XLEN-1] != rs2_q[XLEN-1]) && (diff[XLEN-1] != rs1_q[XLEN-1]);
      end
      4'd7: alu_y = $signed(rs1_q) >>> shamt;
      4'd8: alu_y = {{(XLEN-1){1'b0}}, $signed(rs1_q) < $signed(rs2_q)};
      4'd9: alu_y = {{(XLEN-1){1'b0}}, rs1_q < rs2_q};
      default: alu_y = '0;
    endcase
  end
  assign gnt1 = req1_valid && (!req0_valid || ptr_q);
  assign req0_ready = (state_q == IDLE) && req0_valid && !gnt1;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign acc = req0_ready || req1_ready;
  assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    ctrl_d = ctrl_q;
    rd_d = rd_q;
    zero_d = zero_q;
    carry_d = carry_q;
    ovf_d = ovf_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (acc) begin
        rs1_d = gnt1 ? req1_rs1 : req0_rs1;
        rs2_d = gnt1 ? req1_rs2 : req0_rs2;
        ctrl_d = gnt1 ? req1_ctrl : req0_ctrl;
        owner_d = gnt1;
        ptr_d = !gnt1;
        state_d = EXEC;
      end
      EXEC: begin
        rd_d = illegal ? '0 : alu_y;
        zero_d = illegal || (alu_y == '0);
        carry_d = alu_c;
        ovf_d = alu_v;
        err_d = illegal;
        state_d = RESP;
      end
      RESP: if (rsp_hs) begin
        cnt_d = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      owner_q <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      ctrl_q <= '0;
      rd_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      ctrl_q <= ctrl_d;
      rd_q <= rd_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp_rd = rd_q;
  assign rsp_zero = zero_q;
  assign rsp_carry = carry_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err = err_q;
  assign busy = state_q != IDLE;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a behavioural ALU/arbiter model
module tb_alu_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [63:0] req0_rs1 = 0, req0_rs2 = 0, req1_rs1 = 0, req1_rs2 = 0;
  logic [3:0] req0_ctrl = 0, req1_ctrl = 0;
  logic rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
  logic [63:0] rsp_rd;
  logic rsp_zero, rsp_carry, rsp_overflow, rsp_err, busy;
  logic [31:0] op_count;
  int total = 0, bad = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_rd(rsp_rd), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic c, o, e;
    longint sa, sb, sr;
    sa = a;
    sb = b;
    c = 0;
    o = 0;
    e = 0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin
        r = a + b;
        sr = r;
        c = r < a;
        o = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
      end
      4'd3: r = a ^ b;
      4'd4: r = a << b[5:0];
      4'd5: r = a >> b[5:0];
      4'd6: begin
        r = a - b;
        sr = r;
        c = a < b;
        o = (sa >= 0 && sb < 0 && sr < 0) || (sa < 0 && sb >= 0 && sr >= 0);
      end
      4'd7: r = sa >>> b[5:0];
      4'd8: r = (sa < sb) ? 64'd1 : 64'd0;
      4'd9: r = (a < b) ? 64'd1 : 64'd0;
      default: begin
        r = 0;
        e = 1;
      end
    endcase
    return {e, o, c, r == 0, r};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called and returns at a negedge; the op is handed back after its response handshake
  task automatic drive_op(input bit v0, input bit v1, input logic [3:0] c0, input logic [3:0] c1,
                          input logic [63:0] a0, input logic [63:0] b0, input logic [63:0] a1, input logic [63:0] b1,
                          input int hold, input bit keep, input bit bg0,
                          output int own, output logic [63:0] rd, output logic z, output logic c,
                          output logic o, output logic e, output bit tim_ok, output bit stable);
    int w = 0;
    own = -1; rd = 0; z = 0; c = 0; o = 0; e = 0; tim_ok = 0; stable = 0;
    req0_valid = v0; req0_ctrl = c0; req0_rs1 = a0; req0_rs2 = b0;
    req1_valid = v1; req1_ctrl = c1; req1_rs1 = a1; req1_rs2 = b1;
    #1;
    while (!req0_ready && !req1_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!req0_ready && !req1_ready) return;
    own = req1_ready ? 1 : 0;
    @(negedge clk);
    if (own == 0 || !keep) req0_valid = 0;
    if (own == 1 || !keep) req1_valid = 0;
    #1;
    tim_ok = busy && !rsp0_valid && !rsp1_valid && !req0_ready && !req1_ready;
    @(negedge clk);
    tim_ok = tim_ok && (own == 1 ? (rsp1_valid && !rsp0_valid) : (rsp0_valid && !rsp1_valid));
    rd = rsp_rd; z = rsp_zero; c = rsp_carry; o = rsp_overflow; e = rsp_err;
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      if (own == 1) rsp0_ready = 1'($urandom_range(0, 1));
      else rsp1_ready = 1'($urandom_range(0, 1));
      if (bg0) req0_valid = 1;
      @(negedge clk);
      stable = stable && rsp_rd === rd && rsp_zero === z && rsp_carry === c && rsp_overflow === o
               && rsp_err === e && busy && !req0_ready && !req1_ready
               && (own == 1 ? (rsp1_valid && !rsp0_valid) : (rsp0_valid && !rsp1_valid));
    end
    rsp0_ready = own == 0;
    rsp1_ready = own == 1;
    @(negedge clk);
    rsp0_ready = 0;
    rsp1_ready = 0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++; if (rsp_rd !== 0 || rsp_zero !== 0 || rsp_carry !== 0 || rsp_overflow !== 0 || rsp_err !== 0) begin bad++; $display("FAIL reset_rsp got rd=%h z%b c%b o%b e%b exp all 0", rsp_rd, rsp_zero, rsp_carry, rsp_overflow, rsp_err); end
    total++; if ({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got v0%b v1%b busy%b r0%b r1%b exp 0", rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready); end
    total++; if (op_count !== 0) begin bad++; $display("FAIL reset_count got=%0d exp=0", op_count); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    int own; logic [63:0] rd; logic z, c, o, e; bit t, s;
    drive_op(1, 0, 4'd2, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (own !== 0) begin bad++; $display("FAIL add_grant got=%0d exp=0", own); end
    total++; if (!t) begin bad++; $display("FAIL add_latency got=0 exp=1"); end
    total++; if (rd !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL add_rd got=%h exp=8000000000000000", rd); end
    total++; if ({z, c, o, e} !== 4'b0010) begin bad++; $display("FAIL add_flags got zcoe=%b%b%b%b exp=0010", z, c, o, e); end
    total++; if (op_count !== 1) begin bad++; $display("FAIL add_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_arbitration();
    int own; logic [63:0] rd; logic z, c, o, e; bit t, s;
    do_reset();
    drive_op(1, 1, 4'd6, 4'd6, 64'd5, 64'd5, 64'd0, 64'd1, 0, 1, 0, own, rd, z, c, o, e, t, s);
    total++; if (own !== 0) begin bad++; $display("FAIL arb_first got=%0d exp=0", own); end
    total++; if (rd !== 0 || z !== 1 || c !== 0) begin bad++; $display("FAIL arb_sub0 got rd=%h z%b c%b exp rd=0 z1 c0", rd, z, c); end
    drive_op(0, 1, 4'd6, 4'd6, 64'd5, 64'd5, 64'd0, 64'd1, 0, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (own !== 1 || !t) begin bad++; $display("FAIL arb_second got own=%0d t=%0d exp own=1 t=1", own, t); end
    total++; if (rd !== '1 || c !== 1 || z !== 0 || o !== 0) begin bad++; $display("FAIL arb_sub1 got rd=%h z%b c%b o%b exp rd=ffffffffffffffff z0 c1 o0", rd, z, c, o); end
    total++; if (op_count !== 2) begin bad++; $display("FAIL arb_count got=%0d exp=2", op_count); end
    drive_op(1, 1, 4'd1, 4'd1, 64'd1, 64'd2, 64'd4, 64'd8, 0, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (own !== 0 || rd !== 64'd3) begin bad++; $display("FAIL arb_ptr got own=%0d rd=%h exp own=0 rd=3", own, rd); end
  endtask

  task automatic test_backpressure();
    int own; logic [63:0] rd; logic z, c, o, e; bit t, s;
    drive_op(0, 1, 4'd3, 4'd0, 64'hA, 64'h3, 64'hF0, 64'h0F, 5, 0, 1, own, rd, z, c, o, e, t, s);
    total++; if (own !== 1 || rd !== 0 || z !== 1) begin bad++; $display("FAIL bp_rsp got own=%0d rd=%h z%b exp own=1 rd=0 z1", own, rd, z); end
    total++; if (!s) begin bad++; $display("FAIL bp_stable got=0 exp=1"); end
    total++; if (req0_ready !== 1 || busy !== 0) begin bad++; $display("FAIL bp_release got r0=%b busy=%b exp r0=1 busy=0", req0_ready, busy); end
    drive_op(1, 0, 4'd3, 4'd0, 64'hA, 64'h3, 0, 0, 0, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (own !== 0 || rd !== 64'h9) begin bad++; $display("FAIL bp_next got own=%0d rd=%h exp own=0 rd=9", own, rd); end
  endtask

  task automatic test_illegal();
    int own; logic [63:0] rd; logic z, c, o, e; bit t, s;
    drive_op(1, 0, 4'b1100, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (rd !== 0 || {z, c, o, e} !== 4'b1001) begin bad++; $display("FAIL illegal got rd=%h zcoe=%b%b%b%b exp rd=0 zcoe=1001", rd, z, c, o, e); end
    drive_op(1, 0, 4'd3, 4'd0, 64'hA, 64'h3, 0, 0, 0, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (rd !== 64'h9 || e !== 0 || z !== 0) begin bad++; $display("FAIL legal_after got rd=%h e%b z%b exp rd=9 e0 z0", rd, e, z); end
  endtask

  task automatic test_sll_reset();
    int own; logic [63:0] rd; logic z, c, o, e; bit t, s;
    do_reset();
    drive_op(1, 0, 4'd4, 4'd0, 64'd1, 64'd63, 0, 0, 0, 0, 0, own, rd, z, c, o, e, t, s);
    total++; if (rd !== 64'h8000_0000_0000_0000 || c !== 0 || o !== 0) begin bad++; $display("FAIL sll got rd=%h c%b o%b exp rd=8000000000000000 c0 o0", rd, c, o); end
    total++; if (op_count !== 1) begin bad++; $display("FAIL sll_count got=%0d exp=1", op_count); end
    req1_valid = 1; req1_ctrl = 4'd9; req1_rs1 = 64'd1; req1_rs2 = 64'd2;
    @(negedge clk);
    req1_valid = 0;
    #1;
    total++; if (busy !== 1) begin bad++; $display("FAIL exec_busy got=%b exp=1", busy); end
    rst_n = 0;
    #1;
    total++; if (rsp_rd !== 0 || {rsp_zero, rsp_carry, rsp_overflow, rsp_err, rsp0_valid, rsp1_valid, busy} !== 7'b0 || op_count !== 0) begin bad++; $display("FAIL async_reset got rd=%h flags=%b%b%b%b v=%b%b busy=%b cnt=%0d exp all 0", rsp_rd, rsp_zero, rsp_carry, rsp_overflow, rsp_err, rsp0_valid, rsp1_valid, busy, op_count); end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    total++; if (rsp1_valid !== 0 || busy !== 0 || op_count !== 0) begin bad++; $display("FAIL discard got v1=%b busy=%b cnt=%0d exp 0 0 0", rsp1_valid, busy, op_count); end
  endtask

  task automatic test_random();
    int own, exp_own, ptr_m, cnt_m;
    logic [63:0] rd, a0, b0, a1, b1, er;
    logic z, c, o, e, ez, ec, eo, ee;
    logic [3:0] c0, c1;
    logic [1:0] pat;
    bit t, s;
    do_reset();
    ptr_m = 0;
    cnt_m = 0;
    for (int n = 0; n < 40; n++) begin
      pat = 2'($urandom_range(1, 3));
      c0 = 4'($urandom_range(0, 15)); c1 = 4'($urandom_range(0, 15));
      a0 = pick(); b0 = pick(); a1 = pick(); b1 = pick();
      drive_op(pat[0], pat[1], c0, c1, a0, b0, a1, b1, $urandom_range(0, 3), 0, 0, own, rd, z, c, o, e, t, s);
      exp_own = (pat == 2'b11) ? ptr_m : (pat[1] ? 1 : 0);
      ptr_m = 1 - exp_own;
      cnt_m++;
      {ee, eo, ec, ez, er} = exp_own == 1 ? model(c1, a1, b1) : model(c0, a0, b0);
      total++; if (own !== exp_own || !t || !s) begin bad++; $display("FAIL rnd_seq[%0d] got own=%0d t=%0d s=%0d exp own=%0d t=1 s=1", n, own, t, s, exp_own); end
      total++; if (rd !== er || {z, c, o, e} !== {ez, ec, eo, ee}) begin bad++; $display("FAIL rnd_rsp[%0d] got rd=%h zcoe=%b%b%b%b exp rd=%h zcoe=%b%b%b%b", n, rd, z, c, o, e, er, ez, ec, eo, ee); end
      total++; if (op_count !== 32'(cnt_m)) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, op_count, cnt_m); end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_arbitration();
    test_backpressure();
    test_illegal();
    test_sll_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
